// File: rtl/priority_resolver_param_if.sv
// -----------------------------------------------------------------------------
// priority_resolver_param_if
// Bundles the request, control and result signals of the PIC priority resolver.
//   master : the side that supplies requests and commands (IRR block, INTA
//            sequencer, command decoder, or a testbench).
//   slave  : the resolver itself.
// Requests/control (master -> slave):
//   irr, imr            pending requests and mask (1 = masked)
//   auto_rotate         rotate priority on EOI / auto-EOI acknowledge
//   auto_eoi            do not set ISR on acknowledge
//   inta, eoi, seoi     one-cycle command pulses
//   eoi_level           level cleared by seoi
//   set_prio            one-cycle specific-rotation pulse
//   prio_level          level that becomes lowest priority on set_prio
// Results (slave -> master):
//   int_out             registered interrupt request to the CPU
//   vector_valid        one-cycle pulse after an accepted inta
//   vector, spurious    acknowledged level / no eligible request found
//   isr, lowest_prio    in-service register and current lowest-priority level
// Handshake: inta is a request pulse; the resolver answers exactly one cycle
// later with vector_valid=1 for one cycle. An inta arriving while vector_valid
// is high is dropped, so each response maps to exactly one accepted inta.
// -----------------------------------------------------------------------------
interface priority_resolver_param_if #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
);
  logic [NUM_IRQ-1:0] irr;
  logic [NUM_IRQ-1:0] imr;
  logic               auto_rotate;
  logic               auto_eoi;
  logic               inta;
  logic               eoi;
  logic               seoi;
  logic [IDX_W-1:0]   eoi_level;
  logic               set_prio;
  logic [IDX_W-1:0]   prio_level;

  logic               int_out;
  logic               vector_valid;
  logic [IDX_W-1:0]   vector;
  logic               spurious;
  logic [NUM_IRQ-1:0] isr;
  logic [IDX_W-1:0]   lowest_prio;

  modport master (
    output irr, imr, auto_rotate, auto_eoi, inta, eoi, seoi, eoi_level,
           set_prio, prio_level,
    input  int_out, vector_valid, vector, spurious, isr, lowest_prio
  );

  modport slave (
    input  irr, imr, auto_rotate, auto_eoi, inta, eoi, seoi, eoi_level,
           set_prio, prio_level,
    output int_out, vector_valid, vector, spurious, isr, lowest_prio
  );
endinterface

// File: rtl/priority_resolver_param.sv
// -----------------------------------------------------------------------------
// priority_resolver_param
// Parametrised PIC priority resolver. Picks the highest-ranked unmasked
// request, applies the nesting rule against the in-service register, raises
// int_out, and on acknowledge returns the vector and updates ISR / rotation.
// Ports:
//   clock  : system clock, all state changes on the rising edge
//   reset  : synchronous active-high reset
//   bus    : priority_resolver_param_if.slave (requests, commands, results)
// Ranking: rank(i) = (i - lowest_prio - 1) mod NUM_IRQ, rank 0 is highest.
// No FSM: the block is a set of registers plus combinational resolution.
// -----------------------------------------------------------------------------
module priority_resolver_param #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  priority_resolver_param_if.slave  bus
);

  logic [NUM_IRQ-1:0] r_isr;
  logic [IDX_W-1:0]   r_lowest;
  logic               r_int_out;
  logic               r_vector_valid;
  logic [IDX_W-1:0]   r_vector;
  logic               r_spurious;

  logic [NUM_IRQ-1:0] w_req;
  logic               w_cand_found;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_cand_rank;
  logic               w_isr_found;
  logic [IDX_W-1:0]   w_isr_best;
  logic [IDX_W-1:0]   w_isr_rank;
  logic               w_eligible;
  logic               w_ack;
  logic               w_seoi_ok;
  logic               w_prio_ok;
  logic               w_seoi_rot;
  logic               w_eoi_rot;
  logic               w_aeoi_rot;
  logic [NUM_IRQ-1:0] w_isr_next;
  logic [IDX_W-1:0]   w_lowest_next;

  // Level holding rank k: (low + 1 + k) mod NUM_IRQ. low and k are both below
  // NUM_IRQ, so a single conditional subtraction covers the wrap.
  function automatic logic [IDX_W-1:0] lvl_of(input logic [IDX_W-1:0] low,
                                              input int k);
    int s;
    s = int'(low) + 1 + k;
    if (s >= NUM_IRQ) s = s - NUM_IRQ;
    return IDX_W'(s);
  endfunction

  // Walk levels in rank order; first hit is the best-ranked one.
  always_comb begin
    w_req        = bus.irr & ~bus.imr;
    w_cand_found = 1'b0;
    w_cand       = '0;
    w_cand_rank  = '0;
    w_isr_found  = 1'b0;
    w_isr_best   = '0;
    w_isr_rank   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!w_cand_found && w_req[lvl_of(r_lowest, k)]) begin
        w_cand_found = 1'b1;
        w_cand       = lvl_of(r_lowest, k);
        w_cand_rank  = IDX_W'(k);
      end
      if (!w_isr_found && r_isr[lvl_of(r_lowest, k)]) begin
        w_isr_found = 1'b1;
        w_isr_best  = lvl_of(r_lowest, k);
        w_isr_rank  = IDX_W'(k);
      end
    end
  end

  // Nesting rule: the candidate must strictly outrank everything in service.
  assign w_eligible = w_cand_found && (!w_isr_found || (w_cand_rank < w_isr_rank));

  // The cycle right after an acknowledge belongs to the response; a second
  // inta then is dropped.
  assign w_ack = bus.inta && !r_vector_valid;

  // Level fields wider than the level range (non power-of-two NUM_IRQ) are
  // treated as no-ops rather than wrapping onto a real level.
  assign w_seoi_ok = int'(bus.eoi_level)  < NUM_IRQ;
  assign w_prio_ok = int'(bus.prio_level) < NUM_IRQ;

  // Sources that actually write lowest_prio this cycle; eoi is suppressed by seoi.
  assign w_seoi_rot = bus.seoi && bus.auto_rotate && w_seoi_ok;
  assign w_eoi_rot  = bus.eoi && !bus.seoi && w_isr_found && bus.auto_rotate;
  assign w_aeoi_rot = w_ack && w_eligible && bus.auto_eoi && bus.auto_rotate;

  always_comb begin
    w_isr_next = r_isr;
    if (bus.seoi) begin
      if (w_seoi_ok) w_isr_next[bus.eoi_level] = 1'b0;
    end else if (bus.eoi && w_isr_found) begin
      w_isr_next[w_isr_best] = 1'b0;
    end
    // Applied last so an acknowledge set beats an EOI clear of the same bit.
    if (w_ack && w_eligible && !bus.auto_eoi) w_isr_next[w_cand] = 1'b1;
  end

  always_comb begin
    w_lowest_next = r_lowest;
    if (bus.set_prio && w_prio_ok) w_lowest_next = bus.prio_level;
    else if (w_seoi_rot)           w_lowest_next = bus.eoi_level;
    else if (w_eoi_rot)            w_lowest_next = w_isr_best;
    else if (w_aeoi_rot)           w_lowest_next = w_cand;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_isr          <= '0;
      r_lowest       <= IDX_W'(NUM_IRQ - 1);
      r_int_out      <= 1'b0;
      r_vector_valid <= 1'b0;
      r_vector       <= '0;
      r_spurious     <= 1'b0;
    end else begin
      r_isr          <= w_isr_next;
      r_lowest       <= w_lowest_next;
      r_int_out      <= w_eligible;
      r_vector_valid <= w_ack;
      if (w_ack) begin
        r_vector   <= w_eligible ? w_cand : IDX_W'(NUM_IRQ - 1);
        r_spurious <= !w_eligible;
      end
    end
  end

  assign bus.int_out      = r_int_out;
  assign bus.vector_valid = r_vector_valid;
  assign bus.vector       = r_vector;
  assign bus.spurious     = r_spurious;
  assign bus.isr          = r_isr;
  assign bus.lowest_prio  = r_lowest;

endmodule
